gpio_in_stage: RTL and testbench
================================

GPIO_IN_STAGE -- requirements
Module: gpio_in_stage

Interface
REQ-001 Parameter CW, default 16: width of the commit counter.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 nreset  input  1  reset, asynchronous and active-low.
REQ-004 wr_valid  input  1  write beat present.
REQ-005 wr_ready  output  1  stage accepts a write beat this cycle.
REQ-006 wr_addr  input  3  target: 0=a, 1=b, 2..5=e word 0..3 (word 0 = e[31:0]), 6=discard-shadow, 7=commit.
REQ-007 wr_data  input  32  write payload.
REQ-008 a  output  8  committed operand a for the downstream function block.
REQ-009 b  output  8  committed operand b.
REQ-010 e  output  128  committed operand e.
REQ-011 upd  output  1  one-cycle pulse: committed outputs changed this cycle.
REQ-012 dirty  output  1  shadow holds uncommitted writes.
REQ-013 commit_cnt  output  CW  number of commits performed, wrapping.

Function
REQ-014 A beat transfers only when wr_valid and wr_ready are both high in the same cycle.
REQ-015 Shadow registers sa(8), sb(8), se(128) exist; committed registers drive a, b, e.
REQ-016 Addr 0 writes wr_data[7:0] to sa; addr 1 writes wr_data[7:0] to sb; wr_data[31:8] ignored for both.
REQ-017 Addr 2..5 writes all 32 bits to se word (addr-2); other words unchanged.
REQ-018 Addr 6 reloads shadow from committed values (sa=a, sb=b, se=e) and clears dirty; no upd.
REQ-019 Addr 7 with data ignored starts a commit; allowed when dirty=0 (re-commits identical values, still pulses upd and counts).
REQ-020 FSM states IDLE, COLLECT, COMMIT.
REQ-021 IDLE: wr_ready=1, dirty=0; shadow write -> COLLECT; commit -> COMMIT; addr 6 -> IDLE.
REQ-022 COLLECT: wr_ready=1, dirty=1; shadow write -> COLLECT; addr 6 -> IDLE; commit -> COMMIT.
REQ-023 COMMIT lasts exactly one cycle: wr_ready=0, dirty holds its COLLECT/IDLE value; committed regs load from shadow at the end of this cycle; next state IDLE.
REQ-024 upd is registered: high the cycle after COMMIT, when new a/b/e first appear; latency from accepted commit beat to visible outputs = 2 clock edges.
REQ-025 commit_cnt increments by 1 at the same edge the committed regs load; wraps from 2^CW-1 to 0.
REQ-026 A transfer while wr_ready=0 cannot occur; upstream holding wr_valid during COMMIT is accepted the next cycle unchanged.
REQ-027 Shadow writes after a commit start from the just-committed values (shadow is never cleared by commit).
REQ-028 Outputs a, b, e change only at a commit edge or reset.

Reset
REQ-029 nreset low asynchronously forces: FSM=IDLE, a=0, b=0, e=0, shadow=0, upd=0, dirty=0, commit_cnt=0, wr_ready=0 while asserted.
REQ-030 Reset asserted during COMMIT aborts it: committed regs stay 0, count stays 0.
REQ-031 After nreset deasserts, wr_ready=1 from the first clock edge onward.

Verification
REQ-032 Write a=0x05, b=0x40, e words 0x11111111..0x44444444, commit -> dirty=1 before commit; upd pulse; a=0x05, b=0x40, e=0x44444444_33333333_22222222_11111111; commit_cnt=1.
REQ-033 Write a=0x07 then addr 6 -> dirty=0, a stays at prior value, no upd; a following commit leaves a unchanged.
REQ-034 wr_valid held high across commit followed by addr0=0x09 -> wr_ready=0 exactly one cycle, 0x09 lands in shadow only, a unchanged until next commit.
REQ-035 CW=4, 17 back-to-back commits -> commit_cnt reads 1; 17 upd pulses observed.
REQ-036 Assert nreset mid-COMMIT after writing a=0xFF -> all outputs 0, upd never pulses, commit_cnt=0.
REQ-037 Write addr0 with wr_data=0xABCDEF12 -> after commit a=0x12.

Source files
------------

// File: rtl/gpio_in_stage_if.sv
// Write channel into the GPIO input stage: address/data beats under valid/ready.
// Master drives the beat, slave returns ready.
interface gpio_in_stage_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/gpio_in_stage.sv
// Shadow/commit staging of operands a, b, e for a downstream function block.
// Latency: accepted commit beat -> new a/b/e and upd pulse after 2 clock edges.
// Backpressure: wr_ready drops for exactly the one COMMIT cycle (and while in reset).
module gpio_in_stage #(
    parameter int CW = 16
) (
    input  logic           clk,
    input  logic           nreset,
    gpio_in_stage_if.slave wr,
    output logic [7:0]     a,
    output logic [7:0]     b,
    output logic [127:0]   e,
    output logic           upd,
    output logic           dirty,
    output logic [CW-1:0]  commit_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     sa_q, sa_d, sb_q, sb_d;
    logic [127:0]   se_q, se_d;
    logic [7:0]     a_q, a_d, b_q, b_d;
    logic [127:0]   e_q, e_d;
    logic           upd_q, upd_d;
    logic           dirty_q, dirty_d;
    logic           wr_ready_q, wr_ready_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           xfer;
    logic [1:0]     word_idx;

    assign xfer     = wr.wr_valid && wr_ready_q;
    // Addresses 2..5 map onto e words 0..3; modulo-4 subtraction does the remap.
    assign word_idx = wr.wr_addr[1:0] - 2'd2;

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        se_d    = se_q;
        a_d     = a_q;
        b_d     = b_q;
        e_d     = e_q;
        cnt_d   = cnt_q;
        upd_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (xfer) begin
                    case (wr.wr_addr)
                        3'd0: begin
                            sa_d    = wr.wr_data[7:0];
                            state_d = ST_COLLECT;
                        end
                        3'd1: begin
                            sb_d    = wr.wr_data[7:0];
                            state_d = ST_COLLECT;
                        end
                        3'd6: begin
                            sa_d    = a_q;
                            sb_d    = b_q;
                            se_d    = e_q;
                            state_d = ST_IDLE;
                        end
                        3'd7: state_d = ST_COMMIT;
                        default: begin
                            se_d[{word_idx, 5'b0} +: 32] = wr.wr_data;
                            state_d = ST_COLLECT;
                        end
                    endcase
                end
            end
            ST_COMMIT: begin
                a_d     = sa_q;
                b_d     = sb_q;
                e_d     = se_q;
                cnt_d   = cnt_q + CW'(1);
                upd_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        wr_ready_d = (state_d != ST_COMMIT);
        // dirty follows the state it lands in; COMMIT keeps whatever it had before.
        case (state_d)
            ST_COLLECT: dirty_d = 1'b1;
            ST_COMMIT:  dirty_d = dirty_q;
            default:    dirty_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_IDLE;
            sa_q       <= '0;
            sb_q       <= '0;
            se_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            e_q        <= '0;
            upd_q      <= 1'b0;
            dirty_q    <= 1'b0;
            wr_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            se_q       <= se_d;
            a_q        <= a_d;
            b_q        <= b_d;
            e_q        <= e_d;
            upd_q      <= upd_d;
            dirty_q    <= dirty_d;
            wr_ready_q <= wr_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wr.wr_ready = wr_ready_q;
    assign a           = a_q;
    assign b           = b_q;
    assign e           = e_q;
    assign upd         = upd_q;
    assign dirty       = dirty_q;
    assign commit_cnt  = cnt_q;

endmodule

// File: tb/tb_gpio_in_stage.sv
// Scoreboard bench for gpio_in_stage: directed scenarios plus randomized beats,
// checked against a shadow/commit model built from plain variables and a queue.
module tb_gpio_in_stage;

    localparam int CW = 4;

    typedef struct {
        logic [7:0]    a;
        logic [7:0]    b;
        logic [127:0]  e;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic [7:0]    a, b;
    logic [127:0]  e;
    logic          upd, dirty;
    logic [CW-1:0] commit_cnt;

    gpio_in_stage_if wif ();

    gpio_in_stage #(.CW(CW)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .wr         (wif),
        .a          (a),
        .b          (b),
        .e          (e),
        .upd        (upd),
        .dirty      (dirty),
        .commit_cnt (commit_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int upd_seen = 0;
    exp_t exp_q[$];

    // Reference model state
    logic [7:0]    m_sa, m_sb, m_a, m_b;
    logic [31:0]   m_sw[4];
    logic [31:0]   m_cw[4];
    logic          m_dirty;
    int            m_commits;

    function automatic logic [127:0] pack_e(input logic [31:0] w0, input logic [31:0] w1,
                                            input logic [31:0] w2, input logic [31:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sa = 0; m_sb = 0; m_a = 0; m_b = 0; m_dirty = 0; m_commits = 0;
        for (int i = 0; i < 4; i++) begin
            m_sw[i] = 0;
            m_cw[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_apply(input logic [2:0] addr, input logic [31:0] data);
        exp_t x;
        if (addr == 0) begin
            m_sa = data[7:0]; m_dirty = 1;
        end else if (addr == 1) begin
            m_sb = data[7:0]; m_dirty = 1;
        end else if (addr <= 5) begin
            m_sw[int'(addr) - 2] = data; m_dirty = 1;
        end else if (addr == 6) begin
            m_sa = m_a; m_sb = m_b;
            for (int i = 0; i < 4; i++) m_sw[i] = m_cw[i];
            m_dirty = 0;
        end else begin
            m_a = m_sa; m_b = m_sb;
            for (int i = 0; i < 4; i++) m_cw[i] = m_sw[i];
            m_commits++;
            m_dirty = 0;
            x.a = m_a; x.b = m_b;
            x.e = pack_e(m_cw[0], m_cw[1], m_cw[2], m_cw[3]);
            x.cnt = CW'(m_commits % (1 << CW));
            exp_q.push_back(x);
        end
    endtask

    // Drive a beat at a negedge and hold it until a cycle with wr_ready seen.
    task automatic send(input logic [2:0] addr, input logic [31:0] data, output int stalls);
        @(negedge clk);
        wif.wr_valid = 1'b1;
        wif.wr_addr  = addr;
        wif.wr_data  = data;
        stalls = 0;
        while (!wif.wr_ready && stalls < 8) begin
            @(negedge clk);
            stalls++;
        end
        if (!wif.wr_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: wr_ready stayed 0 for addr %0d", addr);
            wif.wr_valid = 1'b0;
        end else begin
            chk("dirty_at_beat", 128'(dirty), 128'(m_dirty));
            model_apply(addr, data);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        wif.wr_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    // Monitor: every upd pulse pops one expected commit; a/b/e must not move otherwise.
    logic [7:0]   prev_a, prev_b;
    logic [127:0] prev_e;
    logic         prev_nreset = 1'b0;
    always @(negedge clk) begin
        if (nreset && upd) begin
            upd_seen++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL stray_upd: upd=1 with no commit outstanding");
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("commit_a", 128'(a), 128'(x.a));
                chk("commit_b", 128'(b), 128'(x.b));
                chk("commit_e", e, x.e);
                chk("commit_cnt", 128'(commit_cnt), 128'(x.cnt));
            end
        end else if (nreset && prev_nreset) begin
            chk("hold_outputs", {a, b, e[111:0]} ^ {prev_a, prev_b, prev_e[111:0]}, 128'd0);
            chk("hold_e_top", 128'(e[127:112]), 128'(prev_e[127:112]));
        end
        prev_a = a; prev_b = b; prev_e = e; prev_nreset = nreset;
    end

    initial begin
        int st;
        int u0;
        logic [2:0] ad;
        wif.wr_valid = 1'b0;
        wif.wr_addr  = '0;
        wif.wr_data  = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_a", 128'(a), 128'd0);
        chk("rst_e", e, 128'd0);
        chk("rst_upd_dirty", {126'd0, upd, dirty}, 128'd0);
        chk("rst_cnt", 128'(commit_cnt), 128'd0);
        chk("rst_ready", 128'(wif.wr_ready), 128'd0);
        nreset = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 128'(wif.wr_ready), 128'd1);

        // Basic load and commit
        send(3'd0, 32'h05, st);
        send(3'd1, 32'h40, st);
        send(3'd2, 32'h11111111, st);
        send(3'd3, 32'h22222222, st);
        send(3'd4, 32'h33333333, st);
        send(3'd5, 32'h44444444, st);
        send(3'd7, 32'hdeadbeef, st);
        idle(4);
        chk("basic_a", 128'(a), 128'h05);
        chk("basic_b", 128'(b), 128'h40);
        chk("basic_e", e, 128'h44444444_33333333_22222222_11111111);
        chk("basic_cnt", 128'(commit_cnt), 128'd1);
        chk("basic_dirty", 128'(dirty), 128'd0);

        // Discard then commit leaves a unchanged
        u0 = upd_seen;
        send(3'd0, 32'h07, st);
        send(3'd6, 32'h0, st);
        idle(3);
        chk("discard_dirty", 128'(dirty), 128'd0);
        chk("discard_no_upd", 128'(upd_seen - u0), 128'd0);
        send(3'd7, 32'h0, st);
        idle(4);
        chk("discard_commit_a", 128'(a), 128'h05);

        // Commit with valid held, then a write that must stall one cycle
        send(3'd7, 32'h0, st);
        send(3'd0, 32'h09, st);
        chk("commit_stall", 128'(st), 128'd1);
        idle(4);
        chk("stall_a_unchanged", 128'(a), 128'h05);
        chk("stall_dirty", 128'(dirty), 128'd1);
        send(3'd7, 32'h0, st);
        idle(4);
        chk("stall_a_commit", 128'(a), 128'h09);

        // Upper data bits ignored for a
        send(3'd0, 32'hABCDEF12, st);
        send(3'd7, 32'h0, st);
        idle(4);
        chk("trunc_a", 128'(a), 128'h12);

        // Randomized beats
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r < 10)      ad = 3'($urandom_range(0, 5));
            else if (r < 12) ad = 3'd6;
            else             ad = 3'd7;
            send(ad, $urandom, st);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(4);
        chk("random_drain", 128'(exp_q.size()), 128'd0);

        // 17 back-to-back commits from a fresh reset: counter wraps to 1
        @(negedge clk); nreset = 1'b0; model_reset();
        @(negedge clk); nreset = 1'b1;
        u0 = upd_seen;
        for (int i = 0; i < 17; i++) send(3'd7, 32'h0, st);
        idle(4);
        chk("wrap_cnt", 128'(commit_cnt), 128'd1);
        chk("wrap_upd_count", 128'(upd_seen - u0), 128'd17);

        // Reset asserted during COMMIT aborts it
        send(3'd0, 32'hFF, st);
        send(3'd7, 32'h0, st);
        u0 = upd_seen;
        @(posedge clk); #2;
        nreset = 1'b0;
        wif.wr_valid = 1'b0;
        model_reset();
        @(negedge clk);
        chk("abort_a", 128'(a), 128'd0);
        chk("abort_cnt", 128'(commit_cnt), 128'd0);
        chk("abort_ready", 128'(wif.wr_ready), 128'd0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready_after", 128'(wif.wr_ready), 128'd1);
        idle(4);
        chk("abort_no_upd", 128'(upd_seen - u0), 128'd0);
        chk("abort_a_after", 128'(a), 128'd0);
        chk("abort_cnt_after", 128'(commit_cnt), 128'd0);
        chk("final_drain", 128'(exp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
